// File: rtl/if_load_scheduler.sv
// Round-robin arbiter sharing the single SPI read channel among the on-chip loaders.
// Latency: request to config_paulse 1 cycle, rd_done to done 1 cycle; rd_req/data_valid are combinational.
// Backpressure: rd_req follows the granted requester's req_ready; a stall of TO_LIMIT idle XFER cycles latches timeout.
//
// Ports:
//   clk_chip, reset_chip        : clock, synchronous active-high reset
//   req / req_code / req_ready  : per-requester request level, IF code, word-accept
//   gnt / done / data_valid     : one-hot grant, completion pulse, routed rd_valid
//   config_ready/paulse/data    : read-controller start handshake and IF code
//   rd_req / rd_valid / rd_done : FIFO read request, word strobe, transfer complete
//   timeout                     : sticky stall error, cleared only by reset
module if_load_scheduler #(
    parameter int                  NUM_REQ    = 6,
    parameter int                  CODE_WIDTH = 4,
    parameter int                  TO_WIDTH   = 16,
    parameter logic [TO_WIDTH-1:0] TO_LIMIT   = 16'hFFFF
) (
    input  logic                          clk_chip,
    input  logic                          reset_chip,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*CODE_WIDTH-1:0] req_code,
    input  logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic [NUM_REQ-1:0]            data_valid,
    input  logic                          config_ready,
    output logic                          config_paulse,
    output logic [CODE_WIDTH-1:0]         config_data,
    output logic                          rd_req,
    input  logic                          rd_valid,
    input  logic                          rd_done,
    output logic                          timeout
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    typedef logic [IDX_W-1:0] idx_t;

    // Watchdog fires on the idle cycle that would bring the count to TO_LIMIT.
    localparam logic [TO_WIDTH-1:0] WD_LAST = TO_LIMIT - TO_WIDTH'(1);
    localparam idx_t                IDX_MAX = idx_t'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        XFER  = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

    state_t                state;
    idx_t                  rr_ptr;
    idx_t                  idx;
    logic [CODE_WIDTH-1:0] code_q;
    logic [TO_WIDTH-1:0]   wd_cnt;

    logic                  pick_vld;
    idx_t                  pick_idx;
    int                    scan;

    // Scan offsets from highest to lowest so the smallest offset from rr_ptr
    // is the last to write pick_idx; wrap is done by subtraction, so NUM_REQ
    // does not have to be a power of two.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan     = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            scan = int'(rr_ptr) + i;
            if (scan >= NUM_REQ) begin
                scan = scan - NUM_REQ;
            end
            if (req[scan]) begin
                pick_vld = 1'b1;
                pick_idx = idx_t'(scan);
            end
        end
    end

    always_ff @(posedge clk_chip) begin
        if (reset_chip) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            idx           <= '0;
            code_q        <= '0;
            wd_cnt        <= '0;
            gnt           <= '0;
            done          <= '0;
            config_paulse <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            config_paulse <= 1'b0;
            done          <= '0;
            case (state)
                IDLE: begin
                    if (pick_vld && config_ready) begin
                        idx           <= pick_idx;
                        code_q        <= req_code[int'(pick_idx)*CODE_WIDTH +: CODE_WIDTH];
                        gnt           <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                        config_paulse <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd_cnt <= '0;
                    state  <= XFER;
                end
                XFER: begin
                    if (rd_done) begin
                        done  <= gnt;
                        state <= DONE;
                    end else if (rd_valid) begin
                        wd_cnt <= '0;
                    end else if (wd_cnt == WD_LAST) begin
                        timeout <= 1'b1;
                        gnt     <= '0;
                        state   <= ERROR;
                    end else begin
                        wd_cnt <= wd_cnt + TO_WIDTH'(1);
                    end
                end
                DONE: begin
                    rr_ptr <= (idx == IDX_MAX) ? '0 : idx + idx_t'(1);
                    gnt    <= '0;
                    state  <= IDLE;
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign config_data = code_q;

    // Read-side steering is combinational so the FIFO sees the consumer's
    // back-pressure in the same cycle.
    always_comb begin
        data_valid = '0;
        rd_req     = 1'b0;
        if (state == XFER) begin
            data_valid[idx] = rd_valid;
            rd_req          = req_ready[idx];
        end
    end

endmodule

// File: tb/tb_if_load_scheduler.sv
module tb_if_load_scheduler;

    logic        clk_chip = 1'b0;
    logic        reset_chip;
    logic [5:0]  req;
    logic [23:0] req_code;
    logic [5:0]  req_ready;
    logic [5:0]  gnt;
    logic [5:0]  done;
    logic [5:0]  data_valid;
    logic        config_ready;
    logic        config_paulse;
    logic [3:0]  config_data;
    logic        rd_req;
    logic        rd_valid;
    logic        rd_done;
    logic        timeout;

    int n_tests = 0;
    int n_fail  = 0;

    if_load_scheduler #(
        .NUM_REQ   (6),
        .CODE_WIDTH(4),
        .TO_WIDTH  (16),
        .TO_LIMIT  (16'd8)
    ) dut (
        .clk_chip     (clk_chip),
        .reset_chip   (reset_chip),
        .req          (req),
        .req_code     (req_code),
        .req_ready    (req_ready),
        .gnt          (gnt),
        .done         (done),
        .data_valid   (data_valid),
        .config_ready (config_ready),
        .config_paulse(config_paulse),
        .config_data  (config_data),
        .rd_req       (rd_req),
        .rd_valid     (rd_valid),
        .rd_done      (rd_done),
        .timeout      (timeout)
    );

    always #5 clk_chip = ~clk_chip;

    typedef struct packed {
        logic [5:0] req;
        logic [5:0] rdy;
        logic       cfg;
        logic       vld;
        logic       dn;
        logic [5:0] e_gnt;
        logic [5:0] e_done;
        logic [5:0] e_dv;
        logic       e_pl;
        logic [3:0] e_cd;
        logic       e_rr;
        logic       e_to;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag, input logic [3:0] exp_cd);
        chk({tag, ".gnt"},  32'(gnt), 32'h0);
        chk({tag, ".done"}, 32'(done), 32'h0);
        chk({tag, ".dv"},   32'(data_valid), 32'h0);
        chk({tag, ".pl"},   32'(config_paulse), 32'h0);
        chk({tag, ".cd"},   32'(config_data), 32'(exp_cd));
        chk({tag, ".rr"},   32'(rd_req), 32'h0);
        chk({tag, ".to"},   32'(timeout), 32'h0);
    endtask

    task automatic do_reset();
        @(negedge clk_chip);
        reset_chip   = 1'b1;
        req          = '0;
        req_ready    = '0;
        config_ready = 1'b0;
        rd_valid     = 1'b0;
        rd_done      = 1'b0;
        @(negedge clk_chip);
        @(negedge clk_chip);
        reset_chip = 1'b0;
    endtask

    // Waits (bounded) for the ISSUE cycle; returns at that negedge.
    task automatic wait_paulse(input string tag);
        bit seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_chip);
            #1;
            if (config_paulse) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, ".paulse_seen"}, 32'(seen), 32'h1);
    endtask

    task automatic start_single(input string tag);
        @(negedge clk_chip);
        req          = 6'b000100;
        config_ready = 1'b1;
        wait_paulse(tag);
        chk({tag, ".gnt"}, 32'(gnt), 32'h04);
        chk({tag, ".cd"},  32'(config_data), 32'h3);
        config_ready = 1'b0;
    endtask

    initial begin
        int dv_cnt;

        req_code = {4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1};
        do_reset();
        #1;
        chk_idle_outputs("reset", 4'h0);

        // req, rdy, cfg, vld, dn | gnt, done, dv, pl, cd, rr, to
        vecs[0]  = '{6'b000100, 6'b000000, 1'b1, 1'b0, 1'b0, 6'b000000, 6'b000000, 6'b000000, 1'b0, 4'h0, 1'b0, 1'b0};
        vecs[1]  = '{6'b000100, 6'b000000, 1'b0, 1'b0, 1'b0, 6'b000100, 6'b000000, 6'b000000, 1'b1, 4'h3, 1'b0, 1'b0};
        vecs[2]  = '{6'b000100, 6'b000100, 1'b0, 1'b1, 1'b0, 6'b000100, 6'b000000, 6'b000100, 1'b0, 4'h3, 1'b1, 1'b0};
        vecs[3]  = '{6'b000100, 6'b000000, 1'b0, 1'b1, 1'b0, 6'b000100, 6'b000000, 6'b000100, 1'b0, 4'h3, 1'b0, 1'b0};
        vecs[4]  = '{6'b000100, 6'b111011, 1'b0, 1'b0, 1'b0, 6'b000100, 6'b000000, 6'b000000, 1'b0, 4'h3, 1'b0, 1'b0};
        vecs[5]  = '{6'b000100, 6'b000000, 1'b0, 1'b0, 1'b1, 6'b000100, 6'b000000, 6'b000000, 1'b0, 4'h3, 1'b0, 1'b0};
        vecs[6]  = '{6'b000100, 6'b000000, 1'b0, 1'b0, 1'b0, 6'b000100, 6'b000100, 6'b000000, 1'b0, 4'h3, 1'b0, 1'b0};
        vecs[7]  = '{6'b100000, 6'b000000, 1'b0, 1'b0, 1'b0, 6'b000000, 6'b000000, 6'b000000, 1'b0, 4'h3, 1'b0, 1'b0};
        vecs[8]  = '{6'b100000, 6'b000000, 1'b0, 1'b0, 1'b0, 6'b000000, 6'b000000, 6'b000000, 1'b0, 4'h3, 1'b0, 1'b0};
        vecs[9]  = '{6'b100000, 6'b000000, 1'b1, 1'b0, 1'b0, 6'b000000, 6'b000000, 6'b000000, 1'b0, 4'h3, 1'b0, 1'b0};
        vecs[10] = '{6'b100000, 6'b000000, 1'b0, 1'b0, 1'b0, 6'b100000, 6'b000000, 6'b000000, 1'b1, 4'h6, 1'b0, 1'b0};
        vecs[11] = '{6'b100000, 6'b100000, 1'b0, 1'b1, 1'b1, 6'b100000, 6'b000000, 6'b100000, 1'b0, 4'h6, 1'b1, 1'b0};
        vecs[12] = '{6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 6'b100000, 6'b100000, 6'b000000, 1'b0, 4'h6, 1'b0, 1'b0};
        vecs[13] = '{6'b100001, 6'b000000, 1'b1, 1'b0, 1'b0, 6'b000000, 6'b000000, 6'b000000, 1'b0, 4'h6, 1'b0, 1'b0};
        vecs[14] = '{6'b100001, 6'b000000, 1'b0, 1'b0, 1'b0, 6'b000001, 6'b000000, 6'b000000, 1'b1, 4'h1, 1'b0, 1'b0};
        vecs[15] = '{6'b000000, 6'b111110, 1'b0, 1'b1, 1'b1, 6'b000001, 6'b000000, 6'b000001, 1'b0, 4'h1, 1'b0, 1'b0};
        vecs[16] = '{6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 6'b000001, 6'b000001, 6'b000000, 1'b0, 4'h1, 1'b0, 1'b0};
        vecs[17] = '{6'b000000, 6'b000000, 1'b0, 1'b0, 1'b0, 6'b000000, 6'b000000, 6'b000000, 1'b0, 4'h1, 1'b0, 1'b0};

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk_chip);
            req          = vecs[i].req;
            req_ready    = vecs[i].rdy;
            config_ready = vecs[i].cfg;
            rd_valid     = vecs[i].vld;
            rd_done      = vecs[i].dn;
            #1;
            chk($sformatf("vec%0d.gnt", i),  32'(gnt),           32'(vecs[i].e_gnt));
            chk($sformatf("vec%0d.done", i), 32'(done),          32'(vecs[i].e_done));
            chk($sformatf("vec%0d.dv", i),   32'(data_valid),    32'(vecs[i].e_dv));
            chk($sformatf("vec%0d.pl", i),   32'(config_paulse), 32'(vecs[i].e_pl));
            chk($sformatf("vec%0d.cd", i),   32'(config_data),   32'(vecs[i].e_cd));
            chk($sformatf("vec%0d.rr", i),   32'(rd_req),        32'(vecs[i].e_rr));
            chk($sformatf("vec%0d.to", i),   32'(timeout),       32'(vecs[i].e_to));
        end

        // Single request carrying 43 words.
        do_reset();
        start_single("single");
        dv_cnt = 0;
        for (int c = 0; c < 43; c++) begin
            @(negedge clk_chip);
            req_ready = 6'b000100;
            rd_valid  = 1'b1;
            #1;
            if (data_valid == 6'b000100) dv_cnt++;
        end
        @(negedge clk_chip);
        rd_valid = 1'b0;
        rd_done  = 1'b1;
        @(negedge clk_chip);
        rd_done = 1'b0;
        req     = '0;
        #1;
        chk("single.dv_count", 32'(dv_cnt), 32'd43);
        chk("single.done", 32'(done), 32'h04);
        @(negedge clk_chip);
        #1;
        chk_idle_outputs("single.idle", 4'h3);

        // Round robin with all requests held.
        do_reset();
        @(negedge clk_chip);
        req          = 6'b111111;
        config_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            int e;
            e = k % 6;
            wait_paulse($sformatf("rr%0d", k));
            chk($sformatf("rr%0d.gnt", k), 32'(gnt), 32'(6'b000001 << e));
            chk($sformatf("rr%0d.cd", k), 32'(config_data), 32'(e + 1));
            @(negedge clk_chip);
            rd_done = 1'b1;
            @(negedge clk_chip);
            rd_done = 1'b0;
            #1;
            chk($sformatf("rr%0d.done", k), 32'(done), 32'(6'b000001 << e));
        end

        // Back-pressure tracking with 7-cycle stalls that must not time out.
        do_reset();
        start_single("bp");
        for (int c = 0; c < 24; c++) begin
            logic on;
            on = ((c / 3) % 2) == 1;
            @(negedge clk_chip);
            req_ready = on ? 6'b000100 : 6'b111011;
            rd_valid  = (c % 8) == 7;
            #1;
            chk($sformatf("bp%0d.rr", c), 32'(rd_req), 32'(on));
            chk($sformatf("bp%0d.dv", c), 32'(data_valid), rd_valid ? 32'h04 : 32'h0);
            chk($sformatf("bp%0d.to", c), 32'(timeout), 32'h0);
        end
        @(negedge clk_chip);
        rd_valid = 1'b0;
        rd_done  = 1'b1;
        @(negedge clk_chip);
        rd_done = 1'b0;
        #1;
        chk("bp.done", 32'(done), 32'h04);
        chk("bp.to", 32'(timeout), 32'h0);

        // Timeout after 8 idle XFER cycles, sticky until reset.
        do_reset();
        start_single("to");
        req = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_chip);
            req_ready = 6'b000100;
            rd_valid  = 1'b0;
            #1;
            chk($sformatf("to%0d.gnt", c), 32'(gnt), 32'h04);
            chk($sformatf("to%0d.to", c), 32'(timeout), 32'h0);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_chip);
            req          = 6'b111111;
            config_ready = 1'b1;
            rd_valid     = 1'b1;
            rd_done      = 1'b1;
            #1;
            chk($sformatf("err%0d.to", c), 32'(timeout), 32'h1);
            chk($sformatf("err%0d.gnt", c), 32'(gnt), 32'h0);
            chk($sformatf("err%0d.rr", c), 32'(rd_req), 32'h0);
            chk($sformatf("err%0d.pl", c), 32'(config_paulse), 32'h0);
            chk($sformatf("err%0d.dv", c), 32'(data_valid), 32'h0);
            chk($sformatf("err%0d.done", c), 32'(done), 32'h0);
        end
        do_reset();
        #1;
        chk("err.cleared", 32'(timeout), 32'h0);

        // rd_done on the limit cycle wins over the watchdog.
        start_single("lim");
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_chip);
            req_ready = 6'b000100;
            rd_valid  = 1'b0;
            rd_done   = (c == 7);
        end
        @(negedge clk_chip);
        rd_done = 1'b0;
        req     = '0;
        #1;
        chk("lim.done", 32'(done), 32'h04);
        chk("lim.to", 32'(timeout), 32'h0);
        @(negedge clk_chip);
        #1;
        chk("lim.to2", 32'(timeout), 32'h0);

        // Reset mid-XFER: outputs clear, no done pulse.
        do_reset();
        start_single("rst");
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_chip);
            req_ready = 6'b000100;
            rd_valid  = 1'b1;
        end
        @(negedge clk_chip);
        reset_chip = 1'b1;
        rd_done    = 1'b1;
        req        = '0;
        @(negedge clk_chip);
        #1;
        chk_idle_outputs("rst", 4'h0);
        reset_chip = 1'b0;
        rd_done    = 1'b0;
        @(negedge clk_chip);
        #1;
        chk_idle_outputs("rst.after", 4'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
